// File: rtl/dcache_set_array.sv
// rtl/dcache_set_array.sv - N-way set-associative data-cache tag/data/valid/dirty array with victim selection
// Define DCACHE_PLRU_EN for tree pseudo-LRU replacement; otherwise an 8-bit LFSR picks victims.
module dcache_set_array #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32,
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int LINE_W    = 32 * LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        byte_en,
    input  logic [LINE_W-1:0] fill_line,
    output logic              ready,
    output logic              hit,
    output logic [WAY_W-1:0]  hit_way,
    output logic [WAY_W-1:0]  victim_way,
    output logic              victim_valid,
    output logic              victim_dirty,
    output logic [ADDR_W-1:0] victim_addr,
    output logic [LINE_W-1:0] victim_line,
    output logic [31:0]       rdata,
    output logic              rdata_valid
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int SET_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - SET_W - OFF_W - 2;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_FLUSH = 2'b11;

    typedef enum logic {SWEEP, IDLE} state_t;
    state_t           state, state_next;
    logic [SET_W-1:0] sweep_cnt;

    logic [LINE_W-1:0] data_mem  [WAYS][SETS];
    logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
    logic [WAYS-1:0]   valid_mem [SETS];
    logic [WAYS-1:0]   dirty_mem [SETS];

    logic [OFF_W-1:0]  word_idx;
    logic [SET_W-1:0]  set_idx;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        unused_addr;
    logic              accept, rd_hit, wr_hit, fill_acc;
    logic [WAY_W-1:0]  policy_way;
    logic [LINE_W-1:0] hit_line, wr_line;
    logic [31:0]       rd_word;
    logic [WAYS-1:0]   hit_mask, vic_mask;

    assign word_idx    = addr[2 +: OFF_W];
    assign set_idx     = addr[2 + OFF_W +: SET_W];
    assign tag         = addr[ADDR_W-1 -: TAG_W];
    assign unused_addr = addr[1:0];

    assign accept   = req_valid && ready;
    assign rd_hit   = accept && (req_op == OP_READ) && hit;
    assign wr_hit   = accept && (req_op == OP_WRITE) && hit;
    assign fill_acc = accept && (req_op == OP_FILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
        end else begin
            state     <= state_next;
            sweep_cnt <= (state == SWEEP) ? sweep_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SWEEP: if (sweep_cnt == SET_W'(SETS - 1)) state_next = IDLE;
            IDLE:  if (accept && req_op == OP_FLUSH) state_next = SWEEP;
            default: state_next = SWEEP;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    // Lookup is masked during the sweep so stale valid bits never produce a hit.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (state == IDLE && valid_mem[set_idx][w] && tag_mem[w][set_idx] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        victim_way = policy_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mem[set_idx][w]) victim_way = WAY_W'(w);
        end
    end

    assign victim_valid = 1'(valid_mem[set_idx] >> victim_way);
    assign victim_dirty = 1'(dirty_mem[set_idx] >> victim_way);
    assign victim_addr  = {tag_mem[victim_way][set_idx], set_idx, {(OFF_W + 2){1'b0}}};
    assign victim_line  = data_mem[victim_way][set_idx];
    assign hit_line     = data_mem[hit_way][set_idx];
    assign hit_mask     = WAYS'(1) << hit_way;
    assign vic_mask     = WAYS'(1) << victim_way;

    always_comb begin
        rd_word = '0;
        wr_line = hit_line;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (word_idx == OFF_W'(k)) begin
                rd_word = hit_line[32*k +: 32];
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) wr_line[32*k + 8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef DCACHE_PLRU_EN
    localparam int PW  = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int LVL = $clog2(WAYS);

    logic [PW-1:0]    plru_mem [SETS];
    logic [PW-1:0]    plru_next;
    logic [WAY_W-1:0] access_way;
    logic             pick_bit, upd_bit, touch;
    int               pick_node, upd_node;

    assign access_way = (req_op == OP_FILL) ? victim_way : hit_way;
    assign touch      = rd_hit || wr_hit || fill_acc;

    // Tree nodes are heap-ordered: node n has children 2n+1 (lower half) and 2n+2.
    always_comb begin
        policy_way = '0;
        pick_node  = 0;
        pick_bit   = 1'b0;
        for (int l = 0; l < LVL; l++) begin
            pick_bit   = 1'(plru_mem[set_idx] >> pick_node);
            policy_way = WAY_W'({policy_way, pick_bit});
            pick_node  = 2 * pick_node + 1 + int'(pick_bit);
        end
    end

    always_comb begin
        plru_next = plru_mem[set_idx];
        upd_node  = 0;
        upd_bit   = 1'b0;
        for (int l = 0; l < LVL; l++) begin
            upd_bit   = 1'(access_way >> (LVL - 1 - l));
            plru_next = (plru_next & ~(PW'(1) << upd_node)) | (PW'(!upd_bit) << upd_node);
            upd_node  = 2 * upd_node + 1 + int'(upd_bit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == SWEEP) plru_mem[sweep_cnt] <= '0;
            else if (touch)     plru_mem[set_idx]   <= plru_next;
        end
    end
`else
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) lfsr <= 8'h01;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign policy_way = (WAYS > 1) ? lfsr[WAY_W-1:0] : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == SWEEP) begin
                valid_mem[sweep_cnt] <= '0;
                dirty_mem[sweep_cnt] <= '0;
            end else if (wr_hit) begin
                data_mem[hit_way][set_idx] <= wr_line;
                dirty_mem[set_idx]         <= dirty_mem[set_idx] | hit_mask;
            end else if (fill_acc) begin
                data_mem[victim_way][set_idx] <= fill_line;
                tag_mem[victim_way][set_idx]  <= tag;
                valid_mem[set_idx]            <= valid_mem[set_idx] | vic_mask;
                dirty_mem[set_idx]            <= dirty_mem[set_idx] & ~vic_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= rd_hit;
            if (rd_hit) rdata <= rd_word;
        end
    end
endmodule

// File: tb/tb_dcache_set_array.sv
// tb/tb_dcache_set_array.sv - randomized scoreboard bench for dcache_set_array against a behavioural cache model
// Replacement expectations follow DCACHE_PLRU_EN when it is defined.
module tb_dcache_set_array;
    localparam int WAYS       = 2;
    localparam int SETS       = 64;
    localparam int LINE_WORDS = 8;
    localparam int ADDR_W     = 32;
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int SET_W      = $clog2(SETS);
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W     = 32 * LINE_WORDS;
    localparam int LVL        = $clog2(WAYS);
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, FL = 2'b10, FLUSH = 2'b11;

    logic              clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
    logic [1:0]        req_op = 2'b00;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic [3:0]        byte_en = '0;
    logic [LINE_W-1:0] fill_line = '0;
    logic              ready, hit, victim_valid, victim_dirty, rdata_valid;
    logic [WAY_W-1:0]  hit_way, victim_way;
    logic [ADDR_W-1:0] victim_addr;
    logic [LINE_W-1:0] victim_line;
    logic [31:0]       rdata;

    dcache_set_array #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .addr(addr),
        .wdata(wdata), .byte_en(byte_en), .fill_line(fill_line), .ready(ready), .hit(hit),
        .hit_way(hit_way), .victim_way(victim_way), .victim_valid(victim_valid),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_line(victim_line),
        .rdata(rdata), .rdata_valid(rdata_valid)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_err = 0;
    logic [31:0] exp_q[$];

    bit          m_valid [WAYS][SETS];
    bit          m_dirty [WAYS][SETS];
    int unsigned m_tag   [WAYS][SETS];
    logic [31:0] m_data  [WAYS][SETS][LINE_WORDS];
`ifdef DCACHE_PLRU_EN
    bit          m_tree  [SETS][WAYS];
`else
    logic [7:0]  m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'h01;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
`endif

    task automatic check(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rdata_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rdata: unexpected rdata_valid with rdata %0h at %0t", rdata, $time);
            end else begin
                check("rdata", LINE_W'(rdata), LINE_W'(exp_q.pop_front()));
            end
        end
    end

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
`ifdef DCACHE_PLRU_EN
                m_tree[s][w] = 1'b0;
`endif
            end
        end
    endfunction

    function automatic void m_lookup(input int s, input int unsigned t, output bit h, output int way);
        h = 1'b0;
        way = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!h && m_valid[w][s] && m_tag[w][s] == t) begin
                h = 1'b1;
                way = w;
            end
        end
    endfunction

    function automatic int m_victim(input int s);
        int way = 0, node = 1, b;
        for (int w = 0; w < WAYS; w++) if (!m_valid[w][s]) return w;
`ifdef DCACHE_PLRU_EN
        for (int l = 0; l < LVL; l++) begin
            b = int'(m_tree[s][node]);
            way = way * 2 + b;
            node = node * 2 + b;
        end
        return way;
`else
        b = node;
        return (WAYS == 1) ? 0 : (int'(m_lfsr) % WAYS) + (way * b);
`endif
    endfunction

    function automatic void m_touch(input int s, input int way);
`ifdef DCACHE_PLRU_EN
        int node = 1, b;
        for (int l = 0; l < LVL; l++) begin
            b = (way >> (LVL - 1 - l)) & 1;
            m_tree[s][node] = (b == 0);
            node = node * 2 + b;
        end
`else
        if (s < 0 || way < 0) $display("bad touch index");
`endif
    endfunction

    task automatic do_op(input logic [1:0] op, input int unsigned a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [LINE_W-1:0] fl);
        int s, wi, w, vw;
        int unsigned t;
        bit h;
        logic [LINE_W-1:0] ml;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; addr = a; wdata = wd; byte_en = be; fill_line = fl;
        #1;
        s  = int'((a >> (OFF_W + 2)) % SETS);
        t  = a >> (SET_W + OFF_W + 2);
        wi = int'((a >> 2) % LINE_WORDS);
        m_lookup(s, t, h, w);
        vw = m_victim(s);
        check("ready", LINE_W'(ready), LINE_W'(1));
        check("hit", LINE_W'(hit), LINE_W'(h));
        check("hit_way", LINE_W'(hit_way), LINE_W'(h ? w : 0));
        check("victim_way", LINE_W'(victim_way), LINE_W'(vw));
        check("victim_valid", LINE_W'(victim_valid), LINE_W'(m_valid[vw][s]));
        check("victim_dirty", LINE_W'(victim_dirty), LINE_W'(m_dirty[vw][s]));
        if (m_valid[vw][s]) begin
            for (int k = 0; k < LINE_WORDS; k++) ml[32*k +: 32] = m_data[vw][s][k];
            check("victim_addr", LINE_W'(victim_addr),
                  LINE_W'((m_tag[vw][s] << (SET_W + OFF_W + 2)) | (s << (OFF_W + 2))));
            check("victim_line", victim_line, ml);
        end
        case (op)
            RD: if (h) begin
                exp_q.push_back(m_data[w][s][wi]);
                m_touch(s, w);
            end
            WR: if (h) begin
                for (int b = 0; b < 4; b++) if (be[b]) m_data[w][s][wi][8*b +: 8] = wd[8*b +: 8];
                m_dirty[w][s] = 1'b1;
                m_touch(s, w);
            end
            FL: begin
                m_valid[vw][s] = 1'b1;
                m_dirty[vw][s] = 1'b0;
                m_tag[vw][s]   = t;
                for (int k = 0; k < LINE_WORDS; k++) m_data[vw][s][k] = fl[32*k +: 32];
                m_touch(s, vw);
            end
            default: ;
        endcase
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts falling edges until ready; the bench holds an ignored read request during the sweep.
    task automatic wait_ready(input int expected, input string nm);
        int cnt = 0;
        bit hit_seen = 1'b0;
        while (cnt < 4 * SETS) begin
            @(negedge clk);
            cnt++;
            if (ready) break;
            if (hit) hit_seen = 1'b1;
        end
        req_valid = 1'b0;
        check(nm, LINE_W'(cnt), LINE_W'(expected));
        check("sweep_hit", LINE_W'(hit_seen), LINE_W'(0));
    endtask

    task automatic do_flush(input bit with_rst);
        @(negedge clk);
        req_valid = 1'b1; req_op = FLUSH; addr = $urandom;
        #1;
        check("flush_ready", LINE_W'(ready), LINE_W'(1));
        @(posedge clk);
        #1;
        req_op = RD;
        addr = $urandom;
        m_clear();
        if (!with_rst) begin
            wait_ready(SETS + 1, "flush_sweep_len");
        end else begin
            repeat (10) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("midrst_ready", LINE_W'(ready), LINE_W'(0));
            check("midrst_rdata", LINE_W'(rdata), LINE_W'(0));
            rst = 1'b0;
            wait_ready(SETS, "midrst_sweep_len");
        end
    endtask

    function automatic logic [LINE_W-1:0] ramp_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_WORDS; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_WORDS; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned a;
        int s_r, w_r, r;
        bit h_r;
        logic [1:0] op;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", LINE_W'(ready), LINE_W'(0));
        check("rst_rdata", LINE_W'(rdata), LINE_W'(0));
        check("rst_rdata_valid", LINE_W'(rdata_valid), LINE_W'(0));
        m_clear();
        rst = 1'b0;
        req_valid = 1'b1; req_op = RD; addr = $urandom;
        wait_ready(SETS, "reset_sweep_len");

        do_op(RD, 32'h0000_0040, '0, '0, '0);
        do_op(FL, 32'h0000_1020, '0, '0, ramp_line(32'h1000_0000));
        do_op(RD, 32'h0000_102C, '0, '0, '0);
        check("dir_hit_way", LINE_W'(hit_way), LINE_W'(0));
        idle();
        check("dir_rdata_fill", LINE_W'(rdata), LINE_W'(32'h1000_0003));
        do_op(WR, 32'h0000_102C, 32'hAABB_CCDD, 4'b0101, '0);
        do_op(RD, 32'h0000_102C, '0, '0, '0);
        idle();
        check("dir_rdata_bytes", LINE_W'(rdata), LINE_W'(32'h10BB_00DD));
        do_op(FL, 32'h0000_2020, '0, '0, rand_line());
        do_op(RD, 32'h0000_1020, '0, '0, '0);
        do_op(RD, 32'h0000_3020, '0, '0, '0);
`ifdef DCACHE_PLRU_EN
        check("plru_victim_way", LINE_W'(victim_way), LINE_W'(1));
        check("plru_victim_addr", LINE_W'(victim_addr), LINE_W'(32'h0000_2020));
`endif
        do_op(FL, 32'h0000_3020, '0, '0, rand_line());
        do_op(RD, 32'h0000_2020, '0, '0, '0);
        do_op(WR, 32'h0000_F000, 32'h1234_5678, 4'hF, '0);
        do_op(RD, 32'h0000_F000, '0, '0, '0);
        check("wr_miss_hit", LINE_W'(hit), LINE_W'(0));
        do_flush(1'b0);
        do_op(RD, 32'h0000_1020, '0, '0, '0);
        do_op(RD, 32'h0000_102C, '0, '0, '0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_flush(1'b1);
            end else begin
                a = ($urandom_range(1, 6) << (SET_W + OFF_W + 2)) | ($urandom_range(0, 3) << (OFF_W + 2))
                  | ($urandom_range(0, LINE_WORDS - 1) << 2) | $urandom_range(0, 3);
                r = $urandom_range(0, 99);
                op = (r < 40) ? RD : (r < 70) ? WR : FL;
                s_r = int'((a >> (OFF_W + 2)) % SETS);
                m_lookup(s_r, a >> (SET_W + OFF_W + 2), h_r, w_r);
                if (op == FL && h_r) op = RD;
                do_op(op, a, $urandom, 4'($urandom_range(0, 15)), rand_line());
            end
        end
        idle();
        repeat (3) @(negedge clk);
        check("sb_drain", LINE_W'(exp_q.size()), LINE_W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
